// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Sequencer for the obstacle generators of the dodge game. While a game runs,
// it alternates between gap periods and obstacle periods, both counted in
// frames. It picks each new obstacle from a free-running LFSR. It never picks
// the same code twice in a row. It keeps a survived-obstacle count for the
// score display.
//
// Ports:
//   pclk            pixel clock, the only clock
//   rst             synchronous active-high reset
//   game_on         game screen active
//   menu_on         menu screen active
//   frame_tick      one-cycle pulse per frame (hcount=0, vcount=0)
//   obstacle_done   early-finish pulse from the active obstacle module
//   selected        obstacle code, 0 = none, 1..4 = obstacle (3 = lasers)
//   obstacle_active high while an obstacle is selected
//   obstacle_end    one-cycle pulse when an obstacle period ends normally
//   obstacle_count  obstacles survived this game, saturating at 255
module obstacle_scheduler #(
  parameter int         GAP_FRAMES      = 60,
  parameter int         OBSTACLE_FRAMES = 600,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       game_on,
  input  logic       menu_on,
  input  logic       frame_tick,
  input  logic       obstacle_done,
  output logic [3:0] selected,
  output logic       obstacle_active,
  output logic       obstacle_end,
  output logic [7:0] obstacle_count
);

  typedef enum logic [1:0] {IDLE, GAP, ACTIVE} state_t;

  localparam logic [11:0] GAP_LIMIT = 12'(GAP_FRAMES);
  localparam logic [11:0] OBS_LIMIT = 12'(OBSTACLE_FRAMES);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0]  SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t      state_reg, state_next;
  logic [11:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [2:0]  prev_code_reg, prev_code_next;
  logic [3:0]  selected_reg, selected_next;
  logic        active_reg, active_next;
  logic        end_reg, end_next;
  logic [7:0]  count_reg, count_next;

  logic        abort;
  logic [11:0] frame_cnt_inc;
  logic [2:0]  cand;
  logic [2:0]  code;

  assign abort         = menu_on | ~game_on;
  assign frame_cnt_inc = frame_cnt_reg + 12'd1;

  // The candidate comes from the low LFSR bits. On a repeat of the last
  // code, the pick steps to the next code and wraps 4 back to 1.
  assign cand = {1'b0, lfsr_reg[1:0]} + 3'd1;
  assign code = (cand != prev_code_reg) ? cand :
                (cand == 3'd4)          ? 3'd1 : cand + 3'd1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= 12'd0;
      lfsr_reg      <= SEED;
      prev_code_reg <= 3'd0;
      selected_reg  <= 4'd0;
      active_reg    <= 1'b0;
      end_reg       <= 1'b0;
      count_reg     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      lfsr_reg      <= lfsr_next;
      prev_code_reg <= prev_code_next;
      selected_reg  <= selected_next;
      active_reg    <= active_next;
      end_reg       <= end_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    lfsr_next      = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    prev_code_next = prev_code_reg;
    selected_next  = selected_reg;
    active_next    = active_reg;
    end_next       = 1'b0;
    count_next     = count_reg;

    if (abort) begin
      // The count is held so the final score stays on screen.
      state_next     = IDLE;
      frame_cnt_next = 12'd0;
      selected_next  = 4'd0;
      active_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = GAP;
          frame_cnt_next = 12'd0;
          count_next     = 8'd0;
          prev_code_next = 3'd0;
          selected_next  = 4'd0;
          active_next    = 1'b0;
        end
        GAP: begin
          if (frame_tick) begin
            if (frame_cnt_inc == GAP_LIMIT) begin
              state_next     = ACTIVE;
              frame_cnt_next = 12'd0;
              selected_next  = {1'b0, code};
              active_next    = 1'b1;
              prev_code_next = code;
            end else begin
              frame_cnt_next = frame_cnt_inc;
            end
          end
        end
        ACTIVE: begin
          // A coincident early finish and final tick give a single end.
          if (obstacle_done || (frame_tick && frame_cnt_inc == OBS_LIMIT)) begin
            state_next     = GAP;
            frame_cnt_next = 12'd0;
            selected_next  = 4'd0;
            active_next    = 1'b0;
            end_next       = 1'b1;
            count_next     = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
          end else if (frame_tick) begin
            frame_cnt_next = frame_cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign selected        = selected_reg;
  assign obstacle_active = active_reg;
  assign obstacle_end    = end_reg;
  assign obstacle_count  = count_reg;

endmodule
